// File: rtl/ws2811_word_decoder.sv
// ws2811_word_decoder
// Decodes a WS2811-style single-wire pulse stream into WORD_W-bit words.
// Each bit is one high pulse whose length picks 0 or 1. After NUM_WORDS
// words the rest of the frame is passed straight through to chainOut. A low
// period of RESET_CYC cycles ends the frame.
//
// Ports
//   masterClk  : single clock, rising edge
//   reset      : synchronous active-high reset
//   dataIn     : asynchronous serial line (double-synchronised inside)
//   speed400   : 1 = 400 kHz timing (pulse limits doubled), sampled in IDLE
//   wordReady  : consumer accepts wordOut
//   wordOut    : decoded word, MSB received first
//   wordValid  : wordOut holds an unconsumed word
//   frameStart : one-cycle pulse at the first rising edge of a frame
//   frameEnd   : one-cycle pulse when the frame-ending low period completes
//   active     : frame in progress
//   chainOut   : line forwarded downstream (only while forwarding)
//   errGlitch  : one-cycle pulse, high pulse too short
//   errLong    : one-cycle pulse, high pulse too long
//   errPartial : one-cycle pulse, frame ended mid-word
//   overflow   : sticky, a completed word was dropped
module ws2811_word_decoder #(
  parameter int WORD_W        = 8,
  parameter int NUM_WORDS     = 3,
  parameter int CNT_W         = 16,
  parameter int T1H_THRES_CYC = 13,
  parameter int MIN_H_CYC     = 3,
  parameter int MAX_H_CYC     = 32,
  parameter int RESET_CYC     = 800
) (
  input  logic              masterClk,
  input  logic              reset,
  input  logic              dataIn,
  input  logic              speed400,
  input  logic              wordReady,
  output logic [WORD_W-1:0] wordOut,
  output logic              wordValid,
  output logic              frameStart,
  output logic              frameEnd,
  output logic              active,
  output logic              chainOut,
  output logic              errGlitch,
  output logic              errLong,
  output logic              errPartial,
  output logic              overflow
);

  localparam int IDX_W  = $clog2(WORD_W);
  localparam int WCNT_W = $clog2(NUM_WORDS + 1);
  localparam int SH_W   = WORD_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FWD} state_t;

  state_t            state_reg;
  logic              d_meta_reg, d_sync_reg, d_prev_reg;
  logic              rise, fall, low_end;
  logic [CNT_W-1:0]  high_cnt_reg, low_cnt_reg;
  logic              speed_reg;
  logic [SH_W-1:0]   shift_reg;
  logic [IDX_W-1:0]  bit_idx_reg;
  logic [WCNT_W-1:0] word_cnt_reg;
  logic              pend_valid_reg, pend_bit_reg;
  logic [CNT_W-1:0]  thres, min_h, max_h;

  assign rise = d_sync_reg & ~d_prev_reg;
  assign fall = ~d_sync_reg & d_prev_reg;

  // The low counter is about to reach RESET_CYC on this edge.
  assign low_end = ~d_sync_reg && (low_cnt_reg >= CNT_W'(RESET_CYC - 1));

  // Forwarding is a plain pass-through of the synchronised line.
  assign chainOut = (state_reg == FWD) & d_sync_reg;

  always_comb begin
    thres = speed_reg ? CNT_W'(T1H_THRES_CYC * 2) : CNT_W'(T1H_THRES_CYC);
    min_h = speed_reg ? CNT_W'(MIN_H_CYC * 2)     : CNT_W'(MIN_H_CYC);
    max_h = speed_reg ? CNT_W'(MAX_H_CYC * 2)     : CNT_W'(MAX_H_CYC);
  end

  always_ff @(posedge masterClk) begin
    if (reset) begin
      state_reg      <= IDLE;
      d_meta_reg     <= 1'b0;
      d_sync_reg     <= 1'b0;
      d_prev_reg     <= 1'b0;
      high_cnt_reg   <= '0;
      low_cnt_reg    <= '0;
      speed_reg      <= 1'b0;
      shift_reg      <= '0;
      bit_idx_reg    <= '0;
      word_cnt_reg   <= '0;
      pend_valid_reg <= 1'b0;
      pend_bit_reg   <= 1'b0;
      wordOut        <= '0;
      wordValid      <= 1'b0;
      frameStart     <= 1'b0;
      frameEnd       <= 1'b0;
      active         <= 1'b0;
      errGlitch      <= 1'b0;
      errLong        <= 1'b0;
      errPartial     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      d_meta_reg <= dataIn;
      d_sync_reg <= d_meta_reg;
      d_prev_reg <= d_sync_reg;

      frameStart     <= 1'b0;
      frameEnd       <= 1'b0;
      errGlitch      <= 1'b0;
      errLong        <= 1'b0;
      errPartial     <= 1'b0;
      pend_valid_reg <= 1'b0;

      // Consumer handshake; a word loading below on this edge overrides it.
      if (wordValid && wordReady)
        wordValid <= 1'b0;

      if (rise)
        low_cnt_reg <= '0;
      else if (active && !d_sync_reg && low_cnt_reg != CNT_MAX)
        low_cnt_reg <= low_cnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          speed_reg <= speed400;
          if (rise) begin
            state_reg    <= HIGH;
            frameStart   <= 1'b1;
            active       <= 1'b1;
            high_cnt_reg <= CNT_W'(1);
          end
        end
        HIGH: begin
          if (fall) begin
            state_reg <= LOW;
            // Classify now; the bit itself is shifted in on the next edge.
            if (high_cnt_reg < min_h)
              errGlitch <= 1'b1;
            else if (high_cnt_reg > max_h)
              errLong <= 1'b1;
            else begin
              pend_valid_reg <= 1'b1;
              pend_bit_reg   <= (high_cnt_reg > thres);
            end
          end else if (high_cnt_reg != CNT_MAX) begin
            high_cnt_reg <= high_cnt_reg + 1'b1;
          end
        end
        LOW: begin
          if (low_end) begin
            state_reg    <= IDLE;
            frameEnd     <= 1'b1;
            active       <= 1'b0;
            errPartial   <= (bit_idx_reg != '0);
            bit_idx_reg  <= '0;
            word_cnt_reg <= '0;
          end else if (rise) begin
            state_reg    <= HIGH;
            high_cnt_reg <= CNT_W'(1);
          end
        end
        FWD: begin
          if (low_end) begin
            state_reg    <= IDLE;
            frameEnd     <= 1'b1;
            active       <= 1'b0;
            bit_idx_reg  <= '0;
            word_cnt_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Commit the pending bit. Placed after the FSM so that completing the
      // last word wins over a rise seen on the same edge.
      if (pend_valid_reg) begin
        shift_reg <= SH_W'({shift_reg, pend_bit_reg});
        if (bit_idx_reg == IDX_W'(WORD_W - 1)) begin
          bit_idx_reg <= '0;
          if (!wordValid || wordReady) begin
            wordOut   <= {shift_reg, pend_bit_reg};
            wordValid <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
          word_cnt_reg <= word_cnt_reg + 1'b1;
          if (word_cnt_reg == WCNT_W'(NUM_WORDS - 1))
            state_reg <= FWD;
        end else begin
          bit_idx_reg <= bit_idx_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ws2811_word_decoder.sv
// Testbench for ws2811_word_decoder: table of pulses (with expected error
// pulses and decoded bits) for three frames, plus hand-written sequences for
// overflow, chain forwarding, partial frames and mid-frame reset. Decoded
// words are checked against a scoreboard queue filled as stimulus is driven.
module tb_ws2811_word_decoder;

  logic       masterClk = 1'b0;
  logic       reset = 1'b1;
  logic       dataIn = 1'b0;
  logic       speed400 = 1'b0;
  logic       wordReady = 1'b1;
  logic [7:0] wordOut;
  logic       wordValid, frameStart, frameEnd, active, chainOut;
  logic       errGlitch, errLong, errPartial, overflow;

  ws2811_word_decoder dut (
    .masterClk(masterClk), .reset(reset), .dataIn(dataIn), .speed400(speed400),
    .wordReady(wordReady), .wordOut(wordOut), .wordValid(wordValid),
    .frameStart(frameStart), .frameEnd(frameEnd), .active(active),
    .chainOut(chainOut), .errGlitch(errGlitch), .errLong(errLong),
    .errPartial(errPartial), .overflow(overflow)
  );

  always #5 masterClk = ~masterClk;

  int n_vec = 0, n_bad = 0;
  int cyc = 0, last_fall_cyc = 0;
  int n_fs = 0, n_fe = 0, n_gl = 0, n_lg = 0, n_pe = 0, n_words = 0;
  int fe_cyc = 0, pe_cyc = 0;
  int chain_mode = 0;  // 0 none, 1 chainOut == dSync, 2 chainOut == 0
  logic [7:0] sb_q[$];
  logic din_e1 = 1'b0, exp_dsync;
  bit ready_at_edge, prev_valid = 1'b0, fresh;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial forever begin
    @(posedge masterClk);
    cyc++;
    ready_at_edge = wordReady;
    exp_dsync = din_e1;
    din_e1 = dataIn;
    #1;
    fresh = wordValid && (!prev_valid || ready_at_edge);
    if (fresh) begin
      n_words++;
      if (sb_q.size() == 0) begin
        chk("unexpected word", {24'h0, wordOut}, 32'hFFFF_FFFF);
      end else begin
        chk("word value", {24'h0, wordOut}, {24'h0, sb_q.pop_front()});
        chk("word latency", cyc - last_fall_cyc, 4);
      end
    end
    prev_valid = wordValid;
    if (frameStart) n_fs++;
    if (frameEnd) begin n_fe++; fe_cyc = cyc; end
    if (errGlitch) n_gl++;
    if (errLong) n_lg++;
    if (errPartial) begin n_pe++; pe_cyc = cyc; end
    if (chain_mode == 1) chk("chainOut follows dSync", chainOut, exp_dsync);
    else if (chain_mode == 2) chk("chainOut idle", chainOut, 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse(int hi, int lo);
    dataIn = 1'b1;
    repeat (hi) @(negedge masterClk);
    dataIn = 1'b0;
    last_fall_cyc = cyc;
    repeat (lo) @(negedge masterClk);
  endtask

  task automatic send_byte(logic [7:0] v);
    for (int b = 7; b >= 0; b--) pulse(v[b] ? 19 : 8, 8);
  endtask

  task automatic wait_end(string tag, bit exp_partial);
    int fe0 = n_fe, pe0 = n_pe, t = 0;
    dataIn = 1'b0;
    while (n_fe == fe0 && t < 1200) begin
      @(negedge masterClk);
      t++;
    end
    chk({tag, " frameEnd count"}, n_fe - fe0, 1);
    chk({tag, " errPartial count"}, n_pe - pe0, exp_partial);
    if (exp_partial) chk({tag, " errPartial with frameEnd"}, pe_cyc, fe_cyc);
    chk({tag, " frameEnd latency"}, fe_cyc - last_fall_cyc, 802);
    chk({tag, " active after end"}, active, 0);
  endtask

  typedef struct {
    int hi;
    bit spd;
    bit last;
    bit exp_gl;
    bit exp_lg;
    bit exp_bit;
  } vec_t;
  vec_t vt[$];

  function automatic void add(int hi, bit spd, bit last, bit gl, bit lg, bit b);
    vt.push_back('{hi, spd, last, gl, lg, b});
  endfunction

  function automatic void add_byte(logic [7:0] v, bit last);
    for (int b = 7; b >= 0; b--) add(v[b] ? 19 : 8, 0, last && b == 0, 0, 0, v[b]);
  endfunction

  initial begin
    vec_t v;
    logic [7:0] bm_bits;
    int bm_idx, gl0, lg0, fs0, pe0, fe0, w0;
    bit new_frame;

    // Frame A: three words, 19/8 cycle pulses.
    add_byte(8'hA5, 0); add_byte(8'h3C, 0); add_byte(8'hFF, 1);
    // Frame B: pulse limits at their boundaries; valid bits form 0x59.
    add(3, 0, 0, 0, 0, 0);  add(2, 0, 0, 1, 0, 0);  add(32, 0, 0, 0, 0, 1);
    add(33, 0, 0, 0, 1, 0); add(13, 0, 0, 0, 0, 0); add(14, 0, 0, 0, 0, 1);
    add(19, 0, 0, 0, 0, 1); add(8, 0, 0, 0, 0, 0);  add(8, 0, 0, 0, 0, 0);
    add(19, 0, 1, 0, 0, 1);
    // Frame C: 400 kHz timing; valid bits form 0xC3.
    add(38, 1, 0, 0, 0, 1); add(38, 1, 0, 0, 0, 1); add(5, 1, 0, 1, 0, 0);
    add(16, 1, 0, 0, 0, 0); add(19, 1, 0, 0, 0, 0); add(70, 1, 0, 0, 1, 0);
    add(16, 1, 0, 0, 0, 0); add(19, 1, 0, 0, 0, 0); add(64, 1, 0, 0, 0, 1);
    add(52, 1, 1, 0, 0, 1);

    // Reset state.
    repeat (3) @(negedge masterClk);
    chk("reset wordOut", wordOut, 0);
    chk("reset wordValid", wordValid, 0);
    chk("reset active", active, 0);
    chk("reset chainOut", chainOut, 0);
    chk("reset overflow", overflow, 0);
    chk("reset pulses", {frameStart, frameEnd, errGlitch, errLong, errPartial}, 0);
    reset = 1'b0;
    repeat (2) @(negedge masterClk);

    // Table-driven frames.
    chain_mode = 2;
    wordReady = 1'b1;
    bm_bits = '0; bm_idx = 0; new_frame = 1; fs0 = n_fs;
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      if (new_frame) begin
        speed400 = v.spd;
        fs0 = n_fs;
      end
      if (!v.exp_gl && !v.exp_lg) begin
        bm_bits = {bm_bits[6:0], v.exp_bit};
        bm_idx++;
        if (bm_idx == 8) begin
          sb_q.push_back(bm_bits);
          bm_idx = 0;
        end
      end
      gl0 = n_gl; lg0 = n_lg;
      pulse(v.hi, 8);
      chk($sformatf("vec %0d errGlitch", i), n_gl - gl0, v.exp_gl);
      chk($sformatf("vec %0d errLong", i), n_lg - lg0, v.exp_lg);
      if (new_frame) begin
        chk($sformatf("vec %0d frameStart", i), n_fs - fs0, 1);
        chk($sformatf("vec %0d active", i), active, 1);
      end
      new_frame = 0;
      if (v.last) begin
        wait_end($sformatf("vec %0d", i), bm_idx != 0);
        chk("table words drained", sb_q.size(), 0);
        bm_idx = 0;
        new_frame = 1;
        speed400 = 1'b0;
      end
    end

    // Overflow: consumer stalled across two words.
    wordReady = 1'b0;
    sb_q.push_back(8'h12);
    send_byte(8'h12);
    chk("ovf first word valid", wordValid, 1);
    chk("ovf flag after first", overflow, 0);
    send_byte(8'h34);
    chk("ovf word held", wordOut, 8'h12);
    chk("ovf valid held", wordValid, 1);
    chk("ovf flag set", overflow, 1);
    wait_end("ovf", 0);
    wordReady = 1'b1;
    repeat (2) @(negedge masterClk);
    chk("ovf consumed", wordValid, 0);
    chk("ovf sticky", overflow, 1);
    chk("ovf words drained", sb_q.size(), 0);
    reset = 1'b1;
    @(negedge masterClk);
    reset = 1'b0;
    chk("ovf cleared by reset", overflow, 0);
    @(negedge masterClk);

    // Chain forwarding: 32 bits, only 3 words decoded.
    w0 = n_words;
    sb_q.push_back(8'h81); sb_q.push_back(8'h7E); sb_q.push_back(8'h55);
    send_byte(8'h81); send_byte(8'h7E);
    for (int b = 7; b >= 1; b--) pulse((b % 2 == 0) ? 19 : 8, 8);
    pulse(19, 3);          // bit 24 ('1'), dSync is low again after this
    chain_mode = 1;
    repeat (5) @(negedge masterClk);
    gl0 = n_gl; lg0 = n_lg;
    pulse(2, 8);           // would be a glitch if it were decoded
    pulse(40, 8);          // would be too long if it were decoded
    for (int b = 0; b < 6; b++) pulse((b % 2 == 0) ? 19 : 8, 8);
    chk("fwd no errGlitch", n_gl - gl0, 0);
    chk("fwd no errLong", n_lg - lg0, 0);
    wait_end("fwd", 0);
    chain_mode = 2;
    chk("fwd word count", n_words - w0, 3);
    chk("fwd words drained", sb_q.size(), 0);

    // Partial frame: 5 bits then the frame-ending low period.
    w0 = n_words;
    for (int b = 0; b < 5; b++) pulse((b % 2 == 0) ? 19 : 8, 8);
    wait_end("partial", 1);
    chk("partial no word", n_words - w0, 0);

    // Reset in the middle of a word.
    for (int b = 0; b < 3; b++) pulse(19, 8);
    dataIn = 1'b1;
    repeat (5) @(negedge masterClk);
    fe0 = n_fe; pe0 = n_pe;
    reset = 1'b1;
    @(posedge masterClk);
    #2;
    chk("midreset outputs", {wordOut, wordValid, active, chainOut, frameStart,
                             frameEnd, errGlitch, errLong, errPartial, overflow}, 0);
    @(negedge masterClk);
    reset = 1'b0;
    dataIn = 1'b0;
    repeat (900) @(negedge masterClk);
    chk("midreset no frameEnd", n_fe - fe0, 0);
    chk("midreset no errPartial", n_pe - pe0, 0);
    chk("midreset active", active, 0);

    chain_mode = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ws2811_word_decoder.md
WS2811_WORD_DECODER -- requirements
Module: ws2811_word_decoder

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning bits per output word (MSB received first).
REQ-002 SHALL have parameter NUM_WORDS, default 3, meaning words consumed per frame before forwarding starts.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of pulse and low counters.
REQ-004 SHALL have parameter T1H_THRES_CYC, default 13, meaning high-pulse cycle threshold above which a bit decodes as 1 (800 kHz mode).
REQ-005 SHALL have parameter MIN_H_CYC, default 3, meaning the shortest valid high pulse in cycles (800 kHz mode).
REQ-006 SHALL have parameter MAX_H_CYC, default 32, meaning the longest valid high pulse in cycles (800 kHz mode).
REQ-007 SHALL have parameter RESET_CYC, default 800, meaning the low-period length in cycles that ends a frame.
REQ-008 SHALL have port masterClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port dataIn, input, 1 bit: asynchronous ws2811 line.
REQ-011 SHALL have port speed400, input, 1 bit: when 1, T1H_THRES_CYC, MIN_H_CYC and MAX_H_CYC are each doubled (400 kHz mode); sampled only in IDLE.
REQ-012 SHALL have port wordReady, input, 1 bit: consumer accepts wordOut.
REQ-013 SHALL have port wordOut, output, WORD_W bits: decoded word.
REQ-014 SHALL have port wordValid, output, 1 bit: wordOut holds an unconsumed word.
REQ-015 SHALL have ports frameStart and frameEnd, output, 1 bit each: single-cycle pulses.
REQ-016 SHALL have port active, output, 1 bit: a frame is in progress.
REQ-017 SHALL have port chainOut, output, 1 bit: forwarded line to the downstream device.
REQ-018 SHALL have ports errGlitch, errLong and errPartial, output, 1 bit each: single-cycle error pulses.
REQ-019 SHALL have port overflow, output, 1 bit: sticky flag for a dropped word.

Function
REQ-020 SHALL synchronise dataIn through two flops (dSync), plus a third flop (dPrev) for edge detection; rise = dSync & !dPrev, fall = !dSync & dPrev.
REQ-021 SHALL implement states IDLE, HIGH, LOW and FWD.
- IDLE --rise--> HIGH, with a frameStart pulse and active=1.
- HIGH --fall--> LOW.
- LOW --rise--> HIGH.
- LOW, low count reaching RESET_CYC --> IDLE, with a frameEnd pulse and active=0.
REQ-022 SHALL set the high counter to 1 on rise and increment it each HIGH cycle, saturating at 2^CNT_W-1.
REQ-023 SHALL, on fall, decode high count H as follows:
- H < MIN → bit discarded, errGlitch pulse.
- H > MAX → bit discarded, errLong pulse.
- otherwise bit = (H > THRES), shifted in MSB-first.
REQ-024 SHALL clear the low counter on every rise and increment it each cycle dSync=0 while active.
REQ-025 SHALL, when bit WORD_W of a word is shifted, on that same clock edge load wordOut and set wordValid=1 if wordValid=0 or wordReady=1; otherwise drop the word and set overflow=1.
REQ-026 SHALL clear wordValid on the cycle wordValid & wordReady unless a new word loads on that cycle, in which case wordValid stays 1.
REQ-027 SHALL enter FWD once NUM_WORDS words have completed (loaded or dropped) within a frame; in FWD, chainOut = dSync, with no decoding and no errors.
REQ-028 SHALL hold chainOut at 0 in all states other than FWD.
REQ-029 SHALL leave FWD only via the RESET_CYC low condition, going to IDLE with frameEnd and chainOut=0.
REQ-030 SHALL, when a frame ends with 1..WORD_W-1 bits pending, discard them and pulse errPartial together with frameEnd.
REQ-031 SHALL clear the bit index and word counter at frame end.
REQ-032 SHALL have latency from a dataIn edge to its detection of 3 masterClk edges, and the final bit's wordValid SHALL rise 4 edges after the dataIn fall.

Reset
REQ-033 SHALL, with reset high, force the state to IDLE and set to 0 all counters, sync flops, wordOut, wordValid, active, chainOut, all pulse outputs and overflow.
REQ-034 SHALL give reset priority over all events; reset mid-frame SHALL discard the partial word with no errPartial or frameEnd.

Verification
REQ-035 SHALL cover: frame of 24 bits, high times 19/8 cycles (0xA5,0x3C,0xFF), wordReady=1 → three wordValid pulses with those values, frameEnd after 800 low cycles.
REQ-036 SHALL cover: high pulse of 2 cycles → errGlitch, bit count unchanged; high pulse of 40 cycles → errLong.
REQ-037 SHALL cover: wordReady=0 across two words → first word held, overflow=1, second word dropped.
REQ-038 SHALL cover: 32 bits, NUM_WORDS=3 → bits 25..32 appear on chainOut as dSync, only 3 words output.
REQ-039 SHALL cover: speed400=1 with high times 38/16 cycles → correct decode; 19-cycle pulse decodes as 0.
REQ-040 SHALL cover: frame stopped after 5 bits → errPartial with frameEnd; reset asserted mid-word → all outputs 0 the next cycle.
